// File: rtl/muon_event_capture.sv
// muon_event_capture
//   Records a WIN_BINS-sample window of all four ADC channels around a single
//   cycle muon TRIG pulse, PRE_BINS of those samples preceding the trigger, into
//   one of two ping-pong buffers. Each capture is tagged with a 32-bit timestamp.
//   The CPU reads a full buffer through a registered port and then releases it.
//
// Optional build macro: MUON_CAPTURE_DEAD_CNT_EN
//   When it is defined, DEAD_CNT counts TRIGs that arrive during a capture.
//   When it is undefined, DEAD_CNT is tied to 0.
//
// Ports
//   CLK120        in   120 MHz clock
//   RESET         in   synchronous, active-high reset
//   TRIG          in   single-cycle muon trigger
//   ADC0..2       in   WCD PMT samples (ADC_W each)
//   ADC_SSD       in   SSD sample (ADC_W)
//   BUF_RELEASE   in   per-buffer pulse: the CPU is done with that buffer
//   RD_BUF        in   readout buffer select
//   RD_ADDR       in   readout sample index
//   RD_DATA       out  {ADC_SSD, ADC2, ADC1, ADC0} at [RD_BUF][RD_ADDR], 1-cycle latency
//   RD_TIME       out  timestamp of buffer RD_BUF, 1-cycle latency
//   BUF_FULL      out  the buffer holds a complete, unread capture
//   CAPTURING     out  a capture is in progress
//   OVERFLOW_CNT  out  TRIGs lost because both buffers were full (saturating)
//   DEAD_CNT      out  TRIGs seen during a capture (optional, saturating)
module muon_event_capture #(
    parameter int ADC_W    = 12,
    parameter int PRE_BINS = 8,
    parameter int WIN_BINS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                CLK120,
    input  logic                RESET,
    input  logic                TRIG,
    input  logic [ADC_W-1:0]    ADC0,
    input  logic [ADC_W-1:0]    ADC1,
    input  logic [ADC_W-1:0]    ADC2,
    input  logic [ADC_W-1:0]    ADC_SSD,
    input  logic [1:0]          BUF_RELEASE,
    input  logic                RD_BUF,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    output logic [4*ADC_W-1:0]  RD_DATA,
    output logic [31:0]         RD_TIME,
    output logic [1:0]          BUF_FULL,
    output logic                CAPTURING,
    output logic [15:0]         OVERFLOW_CNT,
    output logic [15:0]         DEAD_CNT
);

    localparam int SW = 4 * ADC_W;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_CAPTURE = 1'b1;

    // Free-running timestamp
    logic [31:0] tstamp_q;

    always_ff @(posedge CLK120) begin
        if (RESET) tstamp_q <= '0;
        else       tstamp_q <= tstamp_q + 32'd1;
    end

    // Pre-trigger delay line. The tap at PRE_BINS-1 gives the sample from
    // PRE_BINS cycles earlier. This tap feeds every RAM write, so a trigger
    // sample lands at address PRE_BINS.
    logic [SW-1:0] dly_q [PRE_BINS];

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            for (int i = 0; i < PRE_BINS; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {ADC_SSD, ADC2, ADC1, ADC0};
            for (int i = 1; i < PRE_BINS; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // Capture FSM
    logic [0:0]        state_q, state_d;
    logic              buf_q, buf_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [1:0]        full_q, full_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [31:0]       time_q [2];
    logic              time_we;
    logic              we;
    logic [ADDR_W:0]   waddr;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        k_d     = k_q;
        // Clearing a bit that is already clear does nothing. This also ignores
        // a release of the buffer that is being captured.
        full_d  = full_q & ~BUF_RELEASE;
        ovf_d   = ovf_q;
        time_we = 1'b0;
        we      = 1'b0;
        waddr   = {buf_q, k_q};
        case (state_q)
            S_IDLE: begin
                if (TRIG) begin
                    if (&full_q) begin
                        if (~&ovf_q) ovf_d = ovf_q + 16'd1;
                    end else begin
                        // Pick the lowest-index empty buffer. Write address 0
                        // in the trigger cycle itself.
                        buf_d   = full_q[0];
                        time_we = 1'b1;
                        we      = 1'b1;
                        waddr   = {full_q[0], {ADDR_W{1'b0}}};
                        k_d     = ADDR_W'(1);
                        state_d = S_CAPTURE;
                    end
                end
            end
            default: begin
                we  = 1'b1;
                k_d = k_q + ADDR_W'(1);
                if (k_q == ADDR_W'(WIN_BINS - 1)) begin
                    full_d[buf_q] = 1'b1;
                    state_d       = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            buf_q     <= 1'b0;
            k_q       <= '0;
            full_q    <= '0;
            ovf_q     <= '0;
            time_q[0] <= '0;
            time_q[1] <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            k_q     <= k_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            if (time_we) time_q[buf_d] <= tstamp_q;
        end
    end

`ifdef MUON_CAPTURE_DEAD_CNT_EN
    logic [15:0] dead_q;

    always_ff @(posedge CLK120) begin
        if (RESET)
            dead_q <= '0;
        else if (state_q == S_CAPTURE && TRIG && ~&dead_q)
            dead_q <= dead_q + 16'd1;
    end

    assign DEAD_CNT = dead_q;
`else
    assign DEAD_CNT = '0;
`endif

    // Sample RAM: both buffers in one array, addressed by {buffer, sample}.
    // The read is registered, so a read and a write to the same address in
    // one cycle return the old data.
    logic [SW-1:0] mem [2*WIN_BINS];
    logic [SW-1:0] rd_data_q;
    logic [31:0]   rd_time_q;

    always_ff @(posedge CLK120) begin
        if (we && !RESET) mem[waddr] <= dly_q[PRE_BINS-1];
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            rd_data_q <= '0;
            rd_time_q <= '0;
        end else begin
            rd_data_q <= mem[{RD_BUF, RD_ADDR}];
            rd_time_q <= time_q[RD_BUF];
        end
    end

    assign RD_DATA      = rd_data_q;
    assign RD_TIME      = rd_time_q;
    assign BUF_FULL     = full_q;
    assign CAPTURING    = (state_q == S_CAPTURE);
    assign OVERFLOW_CNT = ovf_q;

endmodule

// File: tb/tb_muon_event_capture.sv
// Self-checking bench for muon_event_capture. The reference model keeps a
// history of every sample by timestamp. When a capture window closes, the model
// fills the whole buffer from that history.
module tb_muon_event_capture;

    localparam int ADC_W = 12;
    localparam int PRE   = 8;
    localparam int WIN   = 32;
    localparam int AW    = 5;

    logic            CLK120 = 1'b0;
    logic            RESET = 1'b1;
    logic            TRIG = 1'b0;
    logic [ADC_W-1:0] ADC0 = '0, ADC1 = '0, ADC2 = '0, ADC_SSD = '0;
    logic [1:0]      BUF_RELEASE = '0;
    logic            RD_BUF = 1'b0;
    logic [AW-1:0]   RD_ADDR = '0;
    logic [4*ADC_W-1:0] RD_DATA;
    logic [31:0]     RD_TIME;
    logic [1:0]      BUF_FULL;
    logic            CAPTURING;
    logic [15:0]     OVERFLOW_CNT, DEAD_CNT;

    muon_event_capture #(.ADC_W(ADC_W), .PRE_BINS(PRE), .WIN_BINS(WIN), .ADDR_W(AW)) dut (
        .CLK120(CLK120), .RESET(RESET), .TRIG(TRIG),
        .ADC0(ADC0), .ADC1(ADC1), .ADC2(ADC2), .ADC_SSD(ADC_SSD),
        .BUF_RELEASE(BUF_RELEASE), .RD_BUF(RD_BUF), .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA), .RD_TIME(RD_TIME), .BUF_FULL(BUF_FULL),
        .CAPTURING(CAPTURING), .OVERFLOW_CNT(OVERFLOW_CNT), .DEAD_CNT(DEAD_CNT)
    );

    always #4 CLK120 = ~CLK120;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [47:0] hist [int];
    logic [47:0] mmem [2][WIN];
    bit          known [2];
    int          tim [2];
    logic [1:0]  mfull = '0;
    bit          busy = 0;
    int          cs = 0;
    int          cb = 0;
    int          tcur = 0;
    int          ovf = 0;
    int          dead = 0;
    bit          ramp = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, tcur);
        end
    endtask

    function automatic logic [47:0] hv(input int t);
        if (t < 0 || !hist.exists(t)) return '0;
        return hist[t];
    endfunction

    function automatic int exp_dead();
`ifdef MUON_CAPTURE_DEAD_CNT_EN
        return dead;
`else
        return 0;
`endif
    endfunction

    // One clock: drive the inputs at the negedge, advance the model at the
    // posedge, and check every output at the next negedge.
    task automatic step(input bit trig, input logic [1:0] rel, input bit rst);
        logic [47:0] smp, exp_d;
        logic [31:0] exp_t;
        logic [1:0]  nf;
        bit          dknown;
        if (ramp) begin
            ADC0 = tcur[11:0]; ADC1 = 12'h111; ADC2 = 12'h222; ADC_SSD = 12'h333;
        end else begin
            ADC0 = 12'($urandom); ADC1 = 12'($urandom);
            ADC2 = 12'($urandom); ADC_SSD = 12'($urandom);
        end
        TRIG = trig; BUF_RELEASE = rel; RESET = rst;
        smp    = {ADC_SSD, ADC2, ADC1, ADC0};
        exp_d  = mmem[RD_BUF][RD_ADDR];
        dknown = known[RD_BUF];
        exp_t  = tim[RD_BUF];
        @(posedge CLK120);
        if (rst) begin
            if (busy) known[cb] = 0;
            tcur = 0; hist.delete(); busy = 0; mfull = '0;
            ovf = 0; dead = 0; tim[0] = 0; tim[1] = 0;
            exp_d = '0; dknown = 1; exp_t = '0;
        end else begin
            hist[tcur] = smp;
            nf = mfull;
            for (int i = 0; i < 2; i++) if (rel[i] && mfull[i]) nf[i] = 1'b0;
            if (busy) begin
                if (trig && dead < 16'hFFFF) dead++;
                if (tcur == cs + WIN - 1) begin
                    for (int k = 0; k < WIN; k++) mmem[cb][k] = hv(cs - PRE + k);
                    known[cb] = 1; nf[cb] = 1'b1; busy = 0;
                end
            end else if (trig) begin
                if (mfull == 2'b11) begin
                    if (ovf < 16'hFFFF) ovf++;
                end else begin
                    cb = mfull[0] ? 1 : 0;
                    busy = 1; cs = tcur; tim[cb] = tcur; known[cb] = 0;
                end
            end
            mfull = nf;
            tcur++;
        end
        @(negedge CLK120);
        TRIG = 1'b0; BUF_RELEASE = '0;
        chk("buf_full", BUF_FULL, mfull);
        chk("capturing", CAPTURING, busy);
        chk("overflow_cnt", OVERFLOW_CNT, ovf);
        chk("dead_cnt", DEAD_CNT, exp_dead());
        chk("rd_time", RD_TIME, exp_t);
        if (dknown) chk("rd_data", RD_DATA, exp_d);
    endtask

    task automatic run_to(input int t);
        while (tcur < t) step(0, 2'b00, 0);
    endtask

    task automatic do_reset();
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
    endtask

    task automatic rd(input bit b, input int a);
        RD_BUF = b; RD_ADDR = AW'(a);
        step(0, 2'b00, 0);
    endtask

    task automatic sweep();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < WIN; a++) rd(b[0], a);
    endtask

    initial begin
        known[0] = 0; known[1] = 0; tim[0] = 0; tim[1] = 0;
        @(negedge CLK120);

        // Reset state
        do_reset();
        chk("rst_full", BUF_FULL, 2'b00);
        chk("rst_capt", CAPTURING, 1'b0);
        chk("rst_data", RD_DATA, '0);
        chk("rst_time", RD_TIME, '0);

        // Ramp, single capture
        ramp = 1;
        do_reset();
        run_to(100); step(1, 2'b00, 0);
        run_to(131);
        chk("ramp_full_131", BUF_FULL, 2'b00);
        step(0, 2'b00, 0);
        chk("ramp_full_132", BUF_FULL, 2'b01);
        chk("ramp_idle_132", CAPTURING, 1'b0);
        rd(0, 8);  chk("ramp_addr8", RD_DATA[11:0], 12'd100);
        chk("ramp_time", RD_TIME, 32'd100);
        chk("ramp_ch_hi", RD_DATA[47:12], 36'h333222111);
        rd(0, 0);  chk("ramp_addr0", RD_DATA[11:0], 12'd92);
        rd(0, 31); chk("ramp_addr31", RD_DATA[11:0], 12'd123);

        // Two buffers, then overflow
        ramp = 0;
        do_reset();
        run_to(100); step(1, 2'b00, 0);
        run_to(140); step(1, 2'b00, 0);
        run_to(180); step(1, 2'b00, 0);
        run_to(230);
        chk("two_full", BUF_FULL, 2'b11);
        chk("two_ovf", OVERFLOW_CNT, 16'd1);
        rd(1, 0); chk("two_time1", RD_TIME, 32'd140);
        sweep();

        // Release and reuse buffer 0
        step(0, 2'b01, 0);
        chk("rel_full", BUF_FULL, 2'b10);
        run_to(300); step(1, 2'b00, 0);
        run_to(340);
        chk("reuse_full", BUF_FULL, 2'b11);
        rd(0, 0); chk("reuse_time0", RD_TIME, 32'd300);
        rd(1, 0); chk("reuse_time1", RD_TIME, 32'd140);
        sweep();

        // Release and TRIG together with both buffers full
        step(1, 2'b01, 0);
        chk("sim_ovf", OVERFLOW_CNT, 16'd2);
        chk("sim_full", BUF_FULL, 2'b10);
        chk("sim_capt", CAPTURING, 1'b0);
        step(0, 2'b00, 0);
        chk("sim_capt2", CAPTURING, 1'b0);

        // TRIG during capture
        do_reset();
        run_to(100); step(1, 2'b00, 0);
        run_to(105); step(1, 2'b00, 0);
        run_to(140);
        chk("dt_full", BUF_FULL, 2'b01);
        chk("dt_ovf", OVERFLOW_CNT, 16'd0);
`ifdef MUON_CAPTURE_DEAD_CNT_EN
        chk("dt_dead", DEAD_CNT, 16'd1);
`else
        chk("dt_dead", DEAD_CNT, 16'd0);
`endif
        rd(0, 0); chk("dt_time", RD_TIME, 32'd100);

        // Reset in the middle of a capture
        do_reset();
        run_to(100); step(1, 2'b00, 0);
        run_to(110);
        do_reset();
        chk("mid_full", BUF_FULL, 2'b00);
        chk("mid_capt", CAPTURING, 1'b0);
        chk("mid_ovf", OVERFLOW_CNT, 16'd0);
        chk("mid_dead", DEAD_CNT, 16'd0);
        run_to(20); step(1, 2'b00, 0);
        run_to(60);
        chk("mid_next_full", BUF_FULL, 2'b01);
        rd(0, 0); chk("mid_next_time", RD_TIME, 32'd20);
        for (int a = 0; a < WIN; a++) rd(0, a);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            RD_BUF  = 1'($urandom);
            RD_ADDR = AW'($urandom);
            step($urandom_range(0, 7) == 0, ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
